// File: rtl/wash_if.sv
// Panel inputs and actuator/display outputs of the wash sequencer.
// The master modport drives the panel side; the slave modport is the sequencer.
interface wash_if;
  logic       sec_tick;
  logic       power_led;
  logic       start_led;
  logic [2:0] model_now;
  logic [3:0] water_level;
  logic [2:0] phase;
  logic [6:0] time_now;
  logic [6:0] time_all;
  logic       inlet_valve;
  logic       drain_valve;
  logic       motor_on;
  logic       motor_fast;
  logic       if_finish;
  logic       buzzer;

  modport master (
    output sec_tick, power_led, start_led, model_now, water_level,
    input  phase, time_now, time_all, inlet_valve, drain_valve,
           motor_on, motor_fast, if_finish, buzzer
  );

  modport slave (
    input  sec_tick, power_led, start_led, model_now, water_level,
    output phase, time_now, time_all, inlet_valve, drain_valve,
           motor_on, motor_fast, if_finish, buzzer
  );
endinterface

// File: rtl/wash_sequencer.sv
// Washer run-time controller: sequences WASH -> RINSE -> SPIN for the selected
// programme, owns the phase/total countdowns and drives valves, motor and buzzer.
module wash_sequencer #(
  parameter int unsigned FILL_SEC = 3,
  parameter int unsigned BUZZ_SEC = 4
) (
  input  logic   clk,
  input  logic   reset,
  wash_if.slave  bus
);

  localparam int unsigned TW  = 7;
  localparam int unsigned LW  = 4;
  localparam int unsigned MW  = 3;
  localparam int unsigned BCW = $clog2(BUZZ_SEC + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WASH  = 3'd1,
    RINSE = 3'd2,
    SPIN  = 3'd3,
    DONE  = 3'd4
  } phase_e;

  // Enabled phases as {spin, rinse, wash}; unused codes run the full programme.
  function automatic logic [2:0] enables(input logic [MW-1:0] m);
    case (m)
      3'b001:  enables = 3'b001;
      3'b010:  enables = 3'b011;
      3'b011:  enables = 3'b010;
      3'b100:  enables = 3'b110;
      3'b101:  enables = 3'b100;
      default: enables = 3'b111;
    endcase
  endfunction

  function automatic logic [TW-1:0] dur(input phase_e p, input logic [LW-1:0] l);
    case (p)
      WASH:    dur = TW'(9) + TW'(l);
      RINSE:   dur = TW'(9) + (TW'(l) << 1);
      SPIN:    dur = TW'(3) + TW'(l);
      default: dur = '0;
    endcase
  endfunction

  function automatic logic [TW-1:0] total(input logic [2:0] en, input logic [LW-1:0] l);
    total = (en[0] ? dur(WASH, l)  : '0)
          + (en[1] ? dur(RINSE, l) : '0)
          + (en[2] ? dur(SPIN, l)  : '0);
  endfunction

  function automatic phase_e first_phase(input logic [2:0] en);
    if (en[0])      first_phase = WASH;
    else if (en[1]) first_phase = RINSE;
    else            first_phase = SPIN;
  endfunction

  function automatic phase_e next_phase(input phase_e p, input logic [2:0] en);
    case (p)
      WASH:    next_phase = en[1] ? RINSE : (en[2] ? SPIN : DONE);
      RINSE:   next_phase = en[2] ? SPIN : DONE;
      default: next_phase = DONE;
    endcase
  endfunction

  phase_e            phase_q, phase_d;
  logic [TW-1:0]     time_now_q, time_now_d;
  logic [TW-1:0]     time_all_q, time_all_d;
  logic [MW-1:0]     model_q, model_d;
  logic [LW-1:0]     level_q, level_d;
  logic [BCW-1:0]    buzz_cnt_q, buzz_cnt_d;
  logic              start_prev_q, start_prev_d;
  logic              inlet_q, inlet_d;
  logic              drain_q, drain_d;
  logic              motor_q, motor_d;
  logic              fast_q, fast_d;
  logic              finish_q, finish_d;
  logic              buzzer_q, buzzer_d;

  logic              start_edge_c;
  logic [2:0]        en_live_c;
  logic [2:0]        en_lat_c;
  logic [LW-1:0]     level_eff_c;
  logic [TW-1:0]     elapsed_c;
  logic              run_c;
  logic              fill_c;
  logic              soak_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q      <= IDLE;
      time_now_q   <= '0;
      time_all_q   <= '0;
      model_q      <= '0;
      level_q      <= '0;
      buzz_cnt_q   <= '0;
      start_prev_q <= 1'b0;
      inlet_q      <= 1'b0;
      drain_q      <= 1'b0;
      motor_q      <= 1'b0;
      fast_q       <= 1'b0;
      finish_q     <= 1'b0;
      buzzer_q     <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      time_now_q   <= time_now_d;
      time_all_q   <= time_all_d;
      model_q      <= model_d;
      level_q      <= level_d;
      buzz_cnt_q   <= buzz_cnt_d;
      start_prev_q <= start_prev_d;
      inlet_q      <= inlet_d;
      drain_q      <= drain_d;
      motor_q      <= motor_d;
      fast_q       <= fast_d;
      finish_q     <= finish_d;
      buzzer_q     <= buzzer_d;
    end
  end

  always_comb begin
    phase_d      = phase_q;
    time_now_d   = time_now_q;
    time_all_d   = time_all_q;
    model_d      = model_q;
    level_d      = level_q;
    buzz_cnt_d   = '0;
    start_prev_d = bus.start_led;
    start_edge_c = bus.start_led & ~start_prev_q;
    en_live_c    = enables(bus.model_now);
    en_lat_c     = enables(model_q);

    if (!bus.power_led) begin
      phase_d = IDLE;
    end else begin
      case (phase_q)
        IDLE: begin
          model_d = bus.model_now;
          level_d = bus.water_level;
          if (start_edge_c) begin
            phase_d    = first_phase(en_live_c);
            time_now_d = dur(phase_d, bus.water_level);
            time_all_d = total(en_live_c, bus.water_level);
          end
        end
        WASH, RINSE, SPIN: begin
          // Pause wins over a coincident tick: counts only move while running.
          if (bus.start_led && bus.sec_tick) begin
            time_all_d = time_all_q - TW'(1);
            if (time_now_q > TW'(1)) begin
              time_now_d = time_now_q - TW'(1);
            end else begin
              phase_d = next_phase(phase_q, en_lat_c);
              if (phase_d == DONE) begin
                time_now_d = '0;
                time_all_d = '0;
              end else begin
                time_now_d = dur(phase_d, level_q);
              end
            end
          end
        end
        DONE: begin
          buzz_cnt_d = buzz_cnt_q;
          if (bus.sec_tick) begin
            if (buzz_cnt_q == BCW'(BUZZ_SEC - 1)) phase_d = IDLE;
            else                                   buzz_cnt_d = buzz_cnt_q + BCW'(1);
          end
        end
        default: phase_d = IDLE;
      endcase
    end

    // IDLE previews the programme that a start would launch right now.
    if (phase_d == IDLE) begin
      time_now_d = dur(first_phase(en_live_c), bus.water_level);
      time_all_d = total(en_live_c, bus.water_level);
    end

    level_eff_c = (phase_q == IDLE) ? bus.water_level : level_q;
    elapsed_c   = dur(phase_d, level_eff_c) - time_now_d;
    run_c       = bus.power_led & bus.start_led;
    soak_c      = (phase_d == WASH) || (phase_d == RINSE);
    fill_c      = elapsed_c < TW'(FILL_SEC);

    inlet_d  = run_c && soak_c && fill_c;
    motor_d  = run_c && ((soak_c && !fill_c) || (phase_d == SPIN));
    drain_d  = run_c && (phase_d == SPIN);
    fast_d   = run_c && (phase_d == SPIN);
    finish_d = (phase_d == DONE) && (phase_q != DONE);
    buzzer_d = (phase_d == DONE);
  end

  assign bus.phase       = phase_q;
  assign bus.time_now    = time_now_q;
  assign bus.time_all    = time_all_q;
  assign bus.inlet_valve = inlet_q;
  assign bus.drain_valve = drain_q;
  assign bus.motor_on    = motor_q;
  assign bus.motor_fast  = fast_q;
  assign bus.if_finish   = finish_q;
  assign bus.buzzer      = buzzer_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: drives on negedge, samples at the following
// negedge, checks each point with an immediate assertion against hand values.
module tb_wash_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  wash_if bus ();

  wash_sequencer #(.FILL_SEC(3), .BUZZ_SEC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int ph, input int tn, input int ta);
    check({tag, ".phase"},    32'(bus.phase),    32'(ph));
    check({tag, ".time_now"}, 32'(bus.time_now), 32'(tn));
    check({tag, ".time_all"}, 32'(bus.time_all), 32'(ta));
  endtask

  task automatic check_act(input string tag, input bit inl, input bit drn, input bit mot,
                           input bit fst, input bit fin, input bit buz);
    check({tag, ".inlet"},  32'(bus.inlet_valve), 32'(inl));
    check({tag, ".drain"},  32'(bus.drain_valve), 32'(drn));
    check({tag, ".motor"},  32'(bus.motor_on),    32'(mot));
    check({tag, ".fast"},   32'(bus.motor_fast),  32'(fst));
    check({tag, ".finish"}, 32'(bus.if_finish),   32'(fin));
    check({tag, ".buzzer"}, 32'(bus.buzzer),      32'(buz));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.sec_tick = 1'b1;
      @(negedge clk) bus.sec_tick = 1'b0;
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b0;
    bus.sec_tick    = 1'b0;
    bus.power_led   = 1'b1;
    bus.start_led   = 1'b0;
    bus.model_now   = 3'b000;
    bus.water_level = 4'd2;

    // Reset state
    step(3);
    check_state("rst", 0, 0, 0);
    check_act("rst", 0, 0, 0, 0, 0, 0);

    // Full programme 000, L=2: W=11 R=13 S=5, total 29
    reset = 1'b1;
    step(1);
    check_state("p0_idle", 0, 11, 29);
    bus.start_led = 1'b1;
    step(1);
    check_state("p0_wash", 1, 11, 29);
    check_act("p0_wash", 1, 0, 0, 0, 0, 0);
    tick(2);
    check_state("p0_fill2", 1, 9, 27);
    check_act("p0_fill2", 1, 0, 0, 0, 0, 0);
    tick(1);
    check_state("p0_agit", 1, 8, 26);
    check_act("p0_agit", 0, 0, 1, 0, 0, 0);
    tick(8);
    check_state("p0_rinse", 2, 13, 18);
    check_act("p0_rinse", 1, 0, 0, 0, 0, 0);
    tick(13);
    check_state("p0_spin", 3, 5, 5);
    check_act("p0_spin", 0, 1, 1, 1, 0, 0);
    tick(4);
    check_state("p0_spin_end", 3, 1, 1);
    tick(1);
    check_state("p0_done", 4, 0, 0);
    check_act("p0_done", 0, 0, 0, 0, 1, 1);
    step(1);
    check_act("p0_done2", 0, 0, 0, 0, 0, 1);
    tick(3);
    check_state("p0_buzz3", 4, 0, 0);
    check("p0_buzz3.buzzer", 32'(bus.buzzer), 32'd1);
    tick(1);
    check_state("p0_idle_end", 0, 11, 29);
    check_act("p0_idle_end", 0, 0, 0, 0, 0, 0);
    step(3);
    check("p0_no_restart", 32'(bus.phase), 32'd0);

    // Programme 011, L=0: rinse only, 9 s
    bus.start_led   = 1'b0;
    bus.model_now   = 3'b011;
    bus.water_level = 4'd0;
    step(1);
    check_state("p3_idle", 0, 9, 9);
    bus.start_led = 1'b1;
    step(1);
    check_state("p3_rinse", 2, 9, 9);
    check_act("p3_rinse", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check($sformatf("p3_stay%0d", i), 32'(bus.phase), 32'd2);
    end
    check("p3_last.time_now", 32'(bus.time_now), 32'd1);
    tick(1);
    check_state("p3_done", 4, 0, 0);
    check("p3_done.finish", 32'(bus.if_finish), 32'd1);
    tick(4);
    check("p3_idle_end", 32'(bus.phase), 32'd0);

    // Pause in WASH at time_now=7, with a tick coinciding with start falling
    bus.start_led   = 1'b0;
    bus.model_now   = 3'b000;
    bus.water_level = 4'd2;
    step(1);
    bus.start_led = 1'b1;
    step(1);
    check_state("ps_wash", 1, 11, 29);
    tick(4);
    check_state("ps_pre", 1, 7, 25);
    check_act("ps_pre", 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    bus.start_led = 1'b0;
    bus.sec_tick  = 1'b1;
    @(negedge clk);
    bus.sec_tick  = 1'b0;
    check_state("ps_fall", 1, 7, 25);
    check_act("ps_fall", 0, 0, 0, 0, 0, 0);
    tick(5);
    check_state("ps_hold", 1, 7, 25);
    check_act("ps_hold", 0, 0, 0, 0, 0, 0);
    bus.start_led = 1'b1;
    step(1);
    check_state("ps_resume", 1, 7, 25);
    check_act("ps_resume", 0, 0, 1, 0, 0, 0);
    tick(1);
    check_state("ps_count", 1, 6, 24);

    // Power loss in RINSE
    tick(6);
    check_state("pw_rinse", 2, 13, 18);
    tick(1);
    check_state("pw_rinse2", 2, 12, 17);
    bus.power_led = 1'b0;
    step(1);
    check_state("pw_off", 0, 11, 29);
    check_act("pw_off", 0, 0, 0, 0, 0, 0);
    bus.power_led = 1'b1;
    step(3);
    check("pw_no_restart", 32'(bus.phase), 32'd0);

    // Reset with a coincident tick mid-SPIN (programme 101, L=2: S=5)
    bus.start_led = 1'b0;
    bus.model_now = 3'b101;
    step(1);
    bus.start_led = 1'b1;
    step(1);
    check_state("rs_spin", 3, 5, 5);
    check_act("rs_spin", 0, 1, 1, 1, 0, 0);
    tick(1);
    check_state("rs_spin2", 3, 4, 4);
    reset        = 1'b0;
    bus.sec_tick = 1'b1;
    step(1);
    bus.sec_tick  = 1'b0;
    bus.start_led = 1'b0;
    check_state("rs_mid", 0, 0, 0);
    check_act("rs_mid", 0, 0, 0, 0, 0, 0);
    step(1);
    reset = 1'b1;
    step(1);
    check_state("rs_idle", 0, 5, 5);

    // Maximum programme 110, L=15: 24+39+18=81; live inputs changed mid-run
    bus.model_now   = 3'b110;
    bus.water_level = 4'd15;
    step(1);
    check_state("mx_idle", 0, 24, 81);
    bus.start_led = 1'b1;
    step(1);
    check_state("mx_wash", 1, 24, 81);
    bus.model_now   = 3'b001;
    bus.water_level = 4'd0;
    tick(24);
    check_state("mx_rinse", 2, 39, 57);
    tick(39);
    check_state("mx_spin", 3, 18, 18);
    tick(17);
    check_state("mx_last", 3, 1, 1);
    tick(1);
    check_state("mx_done", 4, 0, 0);
    check("mx_done.finish", 32'(bus.if_finish), 32'd1);
    bus.start_led = 1'b0;
    step(1);
    bus.start_led = 1'b1;
    step(1);
    check("mx_done_edge", 32'(bus.phase), 32'd4);
    tick(4);
    check("mx_idle", 32'(bus.phase), 32'd0);
    step(3);
    check_state("mx_no_restart", 0, 9, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
